// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer note scheduler: FSM encoding, requester
// indices, field widths and small arbitration helpers.
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int NUM_REQ  = 3;
    localparam int REQ_BEEP = 0;
    localparam int REQ_KEY  = 1;
    localparam int REQ_SONG = 2;
    localparam int NOTE_W   = 3;
    localparam int DUR_W    = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot of the lowest-index (highest-priority) set request.
    function automatic logic [NUM_REQ-1:0] prio_pick(input logic [NUM_REQ-1:0] r);
        logic [NUM_REQ-1:0] g;
        g = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    // Requesters that outrank the one-hot owner (strictly lower index).
    function automatic logic [NUM_REQ-1:0] higher_prio_mask(input logic [NUM_REQ-1:0] owner);
        logic [NUM_REQ-1:0] m;
        logic               hit;
        m   = '0;
        hit = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit) m[i] = 1'b1;
            if (owner[i]) hit = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/buzz_tick_gen.sv
// Duration prescaler: one-cycle tick every TICK_DIV enabled cycles; restart
// forces the count back to zero so each phase starts on a full tick period.
module buzz_tick_gen
    import buzzer_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            CW   = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/buzzer_note_sched.sv
// Buzzer note scheduler: fixed-priority arbitration (beep > key > song) in IDLE,
// then timed PLAY and GAP phases. Define BUZZ_PREEMPT_EN to let a higher-priority
// request cut the current note short.
module buzzer_note_sched
    import buzzer_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*NOTE_W-1:0] note_in,
    input  logic [NUM_REQ*DUR_W-1:0]  dur_in,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        done,
    output logic                      aborted,
    output logic [NOTE_W-1:0]         note_number,
    output logic                      en,
    output logic                      busy
);

    localparam logic [DUR_W-1:0] GAP_LD  = DUR_W'(GAP_TICKS);
    localparam bit               HAS_GAP = (GAP_TICKS != 0);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [DUR_W-1:0]     cnt_q, cnt_d;
    logic                 zero_q, zero_d;
    logic                 en_q, en_d;
    logic [NOTE_W-1:0]    note_q, note_d;

    logic [NUM_REQ-1:0]   grant;
    logic [NOTE_W-1:0]    g_note;
    logic [DUR_W-1:0]     g_dur;
    logic                 tick;
    logic                 restart;

    buzz_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (restart),
        .en_i      (state_q != ST_IDLE),
        .tick_o    (tick)
    );

    always_comb begin
        grant  = prio_pick(req);
        g_note = '0;
        g_dur  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_note = note_in[NOTE_W*i +: NOTE_W];
                g_dur  = dur_in[DUR_W*i +: DUR_W];
            end
        end
    end

`ifdef BUZZ_PREEMPT_EN
    logic abort_q, abort_d;
    logic preempt;
    // A zero-duration grant always completes; it has no note to cut short.
    assign preempt = (state_q != ST_IDLE) && !zero_q && |(req & higher_prio_mask(owner_q));
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ack_d   = '0;
        done_d  = '0;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        en_d    = en_q;
        note_d  = note_q;
        restart = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    ack_d   = grant;
                    owner_d = grant;
                    restart = 1'b1;
                    // dur=0 parks in GAP for one cycle so busy is seen and done follows ack.
                    if (g_dur == '0) begin
                        state_d = ST_GAP;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = ST_PLAY;
                        zero_d  = 1'b0;
                        cnt_d   = g_dur;
                        note_d  = g_note;
                        en_d    = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (cnt_q == DUR_W'(1)) begin
                        done_d  = owner_q;
                        en_d    = 1'b0;
                        restart = 1'b1;
                        if (HAS_GAP) begin
                            state_d = ST_GAP;
                            cnt_d   = GAP_LD;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (zero_q) begin
                    done_d  = owner_q;
                    zero_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (cnt_q == DUR_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef BUZZ_PREEMPT_EN
        abort_d = 1'b0;
        if (preempt) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            cnt_d   = '0;
            done_d  = (state_q == ST_PLAY) ? owner_q : '0;
            abort_d = (state_q == ST_PLAY);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            en_q    <= 1'b0;
            note_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            en_q    <= en_d;
            note_q  <= note_d;
        end
    end

`ifdef BUZZ_PREEMPT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) abort_q <= 1'b0;
        else        abort_q <= abort_d;
    end
    assign aborted = abort_q;
`else
    assign aborted = 1'b0;
`endif

    assign ack         = ack_q;
    assign done        = done_q;
    assign en          = en_q;
    assign note_number = note_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_buzzer_note_sched.sv
// Self-checking bench for buzzer_note_sched (TICK_DIV=4, GAP_TICKS=1): a per-cycle
// expectation timeline is built from the scheduling rules and compared every cycle.
module tb_buzzer_note_sched;

    localparam int T = 4;
    localparam int G = 1;
    localparam int L = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [8:0]  note_in;
    logic [23:0] dur_in;
    logic [2:0]  ack, done, note_number;
    logic        aborted, en, busy;

    always #5 clk = ~clk;

    buzzer_note_sched #(.TICK_DIV(T), .GAP_TICKS(G)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .note_in     (note_in),
        .dur_in      (dur_in),
        .ack         (ack),
        .done        (done),
        .aborted     (aborted),
        .note_number (note_number),
        .en          (en),
        .busy        (busy)
    );

    int n_pass = 0;
    int n_total = 0;
    int last_note = 0;

    logic [2:0] m_ack  [L];
    logic [2:0] m_done [L];
    bit         m_ab   [L];
    bit         m_en   [L];
    bit         m_busy [L];
    int         m_note [L];
    int         nstart [L];

    // Per requester: arrival cycle (-1 = silent), note, duration.
    int arr [3];
    int nt  [3];
    int du  [3];

    task automatic chk(input string tag, input logic [11:0] e);
        logic [11:0] o;
        o = {ack, done, aborted, en, note_number, busy};
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s obs{ack,done,ab,en,note,busy}=%03h exp=%03h", tag, o, e);
    endtask

    task automatic clear_model();
        for (int c = 0; c < L; c++) begin
            m_ack[c]  = '0;
            m_done[c] = '0;
            m_ab[c]   = 1'b0;
            m_en[c]   = 1'b0;
            m_busy[c] = 1'b0;
            m_note[c] = 0;
            nstart[c] = -1;
        end
    endtask

    task automatic fill_notes(input int te);
        int cur;
        cur = last_note;
        for (int c = 0; c <= te; c++) begin
            if (nstart[c] >= 0) cur = nstart[c];
            m_note[c] = cur;
        end
        last_note = cur;
    endtask

    // Serve requests one at a time: whenever the block is idle, the highest-priority
    // arrived requester goes next; each note occupies (dur+GAP)*T cycles.
    task automatic build(output int te);
        bit pend [3];
        int tf, w, g, mn;
        clear_model();
        for (int i = 0; i < 3; i++) pend[i] = (arr[i] >= 0);
        tf = 0;
        while (pend[0] || pend[1] || pend[2]) begin
            w = -1;
            for (int i = 2; i >= 0; i--) if (pend[i] && arr[i] <= tf) w = i;
            if (w < 0) begin
                mn = L;
                for (int i = 0; i < 3; i++) if (pend[i] && arr[i] < mn) mn = arr[i];
                tf = mn;
            end else begin
                g = tf + 1;
                m_ack[g][w] = 1'b1;
                pend[w] = 1'b0;
                if (du[w] == 0) begin
                    m_busy[g]      = 1'b1;
                    m_done[g+1][w] = 1'b1;
                    tf = g + 1;
                end else begin
                    nstart[g] = nt[w];
                    for (int k = 0; k < du[w] * T; k++) m_en[g+k] = 1'b1;
                    for (int k = 0; k < (du[w] + G) * T; k++) m_busy[g+k] = 1'b1;
                    m_done[g + du[w] * T][w] = 1'b1;
                    tf = g + (du[w] + G) * T;
                end
            end
        end
        te = tf;
        fill_notes(te);
    endtask

    task automatic drive(input int c);
        for (int i = 0; i < 3; i++) begin
            if (arr[i] == c) begin
                req[i]             = 1'b1;
                note_in[3*i +: 3]  = 3'(nt[i]);
                dur_in[8*i +: 8]   = 8'(du[i]);
            end
            if (m_ack[c][i]) begin
                req[i]             = 1'b0;
                note_in[3*i +: 3]  = 3'($urandom);
                dur_in[8*i +: 8]   = 8'($urandom);
            end
        end
    endtask

    task automatic run(input string nm, input int te, input int stop);
        drive(0);
        for (int c = 1; c <= te && c <= stop; c++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_c%0d", nm, c),
                {m_ack[c], m_done[c], m_ab[c], m_en[c], 3'(m_note[c]), m_busy[c]});
            drive(c);
        end
    endtask

    task automatic play(input string nm);
        int te;
        build(te);
        run(nm, te, L);
    endtask

    initial begin
        int te;
        rst_n   = 1'b0;
        req     = 3'b111;
        note_in = 9'($urandom);
        dur_in  = 24'($urandom);
        repeat (2) begin
            @(posedge clk); #1;
            chk("reset", 12'h000);
        end
        rst_n = 1'b1;
        req   = '0;
        @(posedge clk); #1;
        chk("idle_after_reset", 12'h000);

        arr = '{-1, -1, 0}; nt = '{0, 0, 5}; du = '{0, 0, 3};
        play("song_single");

        arr = '{0, 0, 0}; nt = '{1, 4, 7}; du = '{1, 2, 1};
        play("all_three");

        arr = '{-1, 0, -1}; nt = '{0, 2, 0}; du = '{0, 0, 0};
        play("key_dur0");

        arr = '{6, -1, 0}; nt = '{2, 0, 3}; du = '{1, 0, 10};
`ifdef BUZZ_PREEMPT_EN
        clear_model();
        m_ack[1] = 3'b100;
        nstart[1] = 3;
        for (int c = 1; c <= 6; c++) begin m_en[c] = 1'b1; m_busy[c] = 1'b1; end
        m_done[7] = 3'b100;
        m_ab[7]   = 1'b1;
        m_ack[8]  = 3'b001;
        nstart[8] = 2;
        for (int c = 8; c <= 11; c++) m_en[c] = 1'b1;
        for (int c = 8; c <= 15; c++) m_busy[c] = 1'b1;
        m_done[12] = 3'b001;
        fill_notes(16);
        run("preempt", 16, L);
`else
        play("no_preempt");
`endif

        arr = '{-1, -1, 0}; nt = '{0, 0, 6}; du = '{0, 0, 5};
        build(te);
        run("rst_mid", te, 6);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_clear", 12'h000);
        rst_n = 1'b1;
        last_note = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_mid_quiet%0d", c), 12'h000);
        end
        arr = '{-1, 0, -1}; nt = '{0, 3, 0}; du = '{0, 2, 0};
        play("after_rst");

        for (int s = 0; s < 10; s++) begin
            int msk;
            msk = int'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                nt[i] = int'($urandom_range(0, 7));
                du[i] = int'($urandom_range(0, 4));
`ifdef BUZZ_PREEMPT_EN
                arr[i] = msk[i] ? 0 : -1;
`else
                arr[i] = msk[i] ? int'($urandom_range(0, 3)) : -1;
`endif
            end
            play($sformatf("rnd%0d", s));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
